// File: rtl/conv_pkg.sv
`default_nettype none
// ============================================================================
// Package  : conv_pkg
// Brief    : Post-processing mode encodings and saturating helpers shared by
//            the convolution blocks.
// Revision : 1.0
// ============================================================================
package conv_pkg;

    localparam logic [1:0] MODE_ABS   = 2'd0;
    localparam logic [1:0] MODE_POS   = 2'd1;
    localparam logic [1:0] MODE_SHIFT = 2'd2;
    localparam logic [1:0] MODE_RAW   = 2'd3;

    function automatic logic [7:0] clamp_u8(input logic signed [31:0] v);
        if (v < 0)
            return 8'd0;
        else if (v > 32'sd255)
            return 8'hFF;
        else
            return v[7:0];
    endfunction

    function automatic logic [7:0] abs_clamp_u8(input logic signed [31:0] v);
        logic signed [31:0] a;
        a = (v < 0) ? -v : v;
        return clamp_u8(a);
    endfunction

endpackage
`default_nettype wire

// File: rtl/conv_line_buf.sv
`default_nettype none
// ============================================================================
// Module   : conv_line_buf
// Brief    : Two IMG_W-deep line buffers returning the column triple
//            {row r-2, row r-1, row r} at the current column.
// Revision : 1.0
// ============================================================================
module conv_line_buf #(
    parameter  int BITW  = 8,
    parameter  int IMG_W = 640,
    localparam int CW    = $clog2(IMG_W)
) (
    input  logic                clk,
    input  logic                i_we,
    input  logic [CW-1:0]       i_col,
    input  logic [BITW-1:0]     i_din,
    output logic [3*BITW-1:0]   o_col
);

    logic [BITW-1:0] r_lb1 [IMG_W];
    logic [BITW-1:0] r_lb2 [IMG_W];

    // Read-before-write: the old entries are the two rows above this pixel.
    assign o_col = {r_lb2[i_col], r_lb1[i_col], i_din};

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_lb2[i_col] <= r_lb1[i_col];
            r_lb1[i_col] <= i_din;
        end
    end

endmodule
`default_nettype wire

// File: rtl/conv3x3_stream.sv
`default_nettype none
// ============================================================================
// Module   : conv3x3_stream
// Brief    : Streaming 3x3 signed convolution with line buffers, shadow
//            kernel and 8-bit post-processing over valid/ready streams.
// Revision : 1.0
// ============================================================================
module conv3x3_stream #(
    parameter int BITW  = 8,
    parameter int KW    = 8,
    parameter int ACCW  = 20,
    parameter int IMG_W = 640,
    parameter int SHIFT = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [9*KW-1:0]     k_in,
    input  logic                k_load,
    input  logic [1:0]          mode,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [BITW-1:0]     s_data,
    input  logic                s_sof,
    output logic                m_valid,
    input  logic                m_ready,
    output logic [7:0]          m_data,
    output logic                m_sof,
    output logic                m_eol
);
    import conv_pkg::*;

    localparam int            CW         = $clog2(IMG_W);
    localparam int            PW         = KW + BITW + 1;
    localparam logic [CW-1:0] C_COL_LAST = CW'(IMG_W - 1);

    logic                     w_adv, w_take, w_full;
    logic [CW-1:0]            w_col;
    logic [15:0]              w_row;
    logic [3*BITW-1:0]        w_colv;
    logic signed [ACCW-1:0]   w_sum, w_sh;
    logic [7:0]               w_pp;

    logic [CW-1:0]            r_col;
    logic [15:0]              r_row;
    logic                     r_active;
    logic [9*KW-1:0]          r_kshadow, r_kact;
    logic [1:0]               r_mode, r_mode2;
    logic                     r_v1, r_sof1, r_eol1;
    logic                     r_v2, r_sof2, r_eol2;
    logic [BITW-1:0]          r_win  [3][3];
    logic signed [PW-1:0]     r_prod [9];

    assign w_adv   = m_ready || !m_valid;
    assign s_ready = w_adv;
    assign w_take  = s_valid && w_adv && (s_sof || r_active);
    assign w_col   = s_sof ? '0 : r_col;
    assign w_row   = s_sof ? '0 : r_row;
    assign w_full  = (w_row >= 16'd2) && (w_col >= CW'(2));

    conv_line_buf #(
        .BITW  (BITW),
        .IMG_W (IMG_W)
    ) u_line_buf (
        .clk   (clk),
        .i_we  (w_take),
        .i_col (w_col),
        .i_din (s_data),
        .o_col (w_colv)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_col     <= '0;
            r_row     <= '0;
            r_active  <= 1'b0;
            r_kshadow <= '0;
            r_kact    <= '0;
            r_mode    <= MODE_ABS;
        end else begin
            if (k_load)
                r_kshadow <= k_in;
            if (w_take) begin
                if (w_col == C_COL_LAST) begin
                    r_col <= '0;
                    r_row <= (w_row == 16'hFFFF) ? w_row : w_row + 16'd1;
                end else begin
                    r_col <= w_col + CW'(1);
                    r_row <= w_row;
                end
                // A same-cycle k_load bypasses the shadow so the new frame uses it.
                if (s_sof) begin
                    r_active <= 1'b1;
                    r_kact   <= k_load ? k_in : r_kshadow;
                    r_mode   <= mode;
                end
            end
        end
    end

    // Control travels with the data so a kernel/mode swap never hits in-flight windows.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v1    <= 1'b0;
            r_sof1  <= 1'b0;
            r_eol1  <= 1'b0;
            r_v2    <= 1'b0;
            r_sof2  <= 1'b0;
            r_eol2  <= 1'b0;
            r_mode2 <= MODE_ABS;
            m_valid <= 1'b0;
            m_data  <= 8'd0;
            m_sof   <= 1'b0;
            m_eol   <= 1'b0;
        end else if (w_adv) begin
            r_v1    <= w_take && w_full;
            r_sof1  <= (w_row == 16'd2) && (w_col == CW'(2));
            r_eol1  <= (w_col == C_COL_LAST);
            r_v2    <= r_v1;
            r_sof2  <= r_sof1;
            r_eol2  <= r_eol1;
            r_mode2 <= r_mode;
            m_valid <= r_v2;
            m_sof   <= r_v2 && r_sof2;
            m_eol   <= r_v2 && r_eol2;
            if (r_v2)
                m_data <= w_pp;
        end
    end

    always_ff @(posedge clk) begin
        if (w_take) begin
            for (int r = 0; r < 3; r++) begin
                r_win[r][0] <= r_win[r][1];
                r_win[r][1] <= r_win[r][2];
                r_win[r][2] <= w_colv[(2-r)*BITW +: BITW];
            end
        end
        if (w_adv) begin
            for (int i = 0; i < 9; i++)
                r_prod[i] <= PW'($signed(r_kact[i*KW +: KW])) *
                             PW'($signed({1'b0, r_win[i/3][i%3]}));
        end
    end

    always_comb begin
        w_sum = '0;
        for (int i = 0; i < 9; i++)
            w_sum = w_sum + ACCW'(r_prod[i]);
    end

    assign w_sh = w_sum >>> SHIFT;

    always_comb begin
        w_pp = 8'd0;
        case (r_mode2)
            MODE_ABS:   w_pp = abs_clamp_u8(32'(w_sum));
            MODE_POS:   w_pp = clamp_u8(32'(w_sum));
            MODE_SHIFT: w_pp = abs_clamp_u8(32'(w_sh));
            default:    w_pp = w_sum[7:0];
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_conv3x3_stream.sv
`default_nettype none
// ============================================================================
// Module   : tb_conv3x3_stream
// Brief    : Self-checking bench for conv3x3_stream (IMG_W=5, SHIFT=2).
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_conv3x3_stream;

    localparam int W    = 5;
    localparam int KW   = 8;
    localparam int BITW = 8;
    localparam int SH   = 2;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [9*KW-1:0]    k_in = '0;
    logic               k_load = 1'b0;
    logic [1:0]         mode = 2'd0;
    logic               s_valid = 1'b0;
    logic               s_ready;
    logic [BITW-1:0]    s_data = '0;
    logic               s_sof = 1'b0;
    logic               m_valid;
    logic               m_ready;
    logic [7:0]         m_data;
    logic               m_sof;
    logic               m_eol;

    always #5 clk = ~clk;

    conv3x3_stream #(
        .BITW  (BITW),
        .KW    (KW),
        .ACCW  (20),
        .IMG_W (W),
        .SHIFT (SH)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .k_in    (k_in),
        .k_load  (k_load),
        .mode    (mode),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .s_sof   (s_sof),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .m_sof   (m_sof),
        .m_eol   (m_eol)
    );

    typedef struct packed {
        logic [7:0] d;
        logic       sof;
        logic       eol;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   n_cmp = 0;
    int   n_err = 0;
    int   n_out = 0;
    bit   bp_en = 1'b0;
    bit   rdy_force = 1'b1;
    bit   stall_chk = 1'b1;
    bit   gap_en = 1'b0;
    int   img [8][W];
    int   kern [9];

    logic [7:0] prev_d;
    logic       prev_sof, prev_eol;
    bit         prev_stall = 1'b0;

    always @(posedge clk) begin
        #1;
        m_ready = bp_en ? 1'($urandom_range(0, 1)) : rdy_force;
    end

    // Output monitor: ordered scoreboard plus hold-while-stalled check.
    always @(negedge clk) begin
        if (stall_chk && prev_stall) begin
            n_cmp++;
            assert (m_valid === 1'b1 && m_data === prev_d && m_sof === prev_sof && m_eol === prev_eol)
            else begin
                n_err++;
                $error("FAIL stall_hold: observed v=%b d=%0d sof=%b eol=%b expected v=1 d=%0d sof=%b eol=%b",
                       m_valid, m_data, m_sof, m_eol, prev_d, prev_sof, prev_eol);
            end
        end
        prev_stall = stall_chk && (m_valid === 1'b1) && (m_ready === 1'b0);
        prev_d     = m_data;
        prev_sof   = m_sof;
        prev_eol   = m_eol;
        if (m_valid === 1'b1 && m_ready === 1'b1) begin
            n_out++;
            n_cmp++;
            assert (q.size() != 0)
            else begin
                n_err++;
                $error("FAIL unexpected_out: observed d=%0d with expected queue size 0", m_data);
            end
            if (q.size() != 0) begin
                e = q.pop_front();
                n_cmp++;
                assert (m_data === e.d && m_sof === e.sof && m_eol === e.eol)
                else begin
                    n_err++;
                    $error("FAIL out_beat: observed d=%0d sof=%b eol=%b expected d=%0d sof=%b eol=%b",
                           m_data, m_sof, m_eol, e.d, e.sof, e.eol);
                end
            end
        end
    end

    function automatic logic [9*KW-1:0] pack_kern();
        logic [9*KW-1:0] v;
        for (int i = 0; i < 9; i++)
            v[i*KW +: KW] = KW'(kern[i]);
        return v;
    endfunction

    function automatic int post(input int s, input logic [1:0] md);
        int v;
        case (md)
            2'd0: begin v = (s < 0) ? -s : s; if (v > 255) v = 255; end
            2'd1: v = (s < 0) ? 0 : ((s > 255) ? 255 : s);
            2'd2: begin v = s >>> SH; v = (v < 0) ? -v : v; if (v > 255) v = 255; end
            default: v = s & 255;
        endcase
        return v;
    endfunction

    task automatic push_exp(input int d, input bit sof, input bit eol);
        q.push_back('{d: 8'(d), sof: sof, eol: eol});
    endtask

    // Reference: every complete 3x3 window of the stored frame, raster order.
    task automatic model_frame(input int h, input logic [1:0] md);
        int s;
        for (int r = 2; r < h; r++)
            for (int c = 2; c < W; c++) begin
                s = 0;
                for (int i = 0; i < 3; i++)
                    for (int j = 0; j < 3; j++)
                        s += kern[i*3+j] * img[r-2+i][c-2+j];
                push_exp(post(s, md), (r == 2 && c == 2), (c == W-1));
            end
    endtask

    task automatic load_kernel();
        k_in   = pack_kern();
        k_load = 1'b1;
        @(posedge clk); #1;
        k_load = 1'b0;
    endtask

    task automatic send(input logic [7:0] px, input logic sof, input logic kld);
        int t;
        if (gap_en) begin
            s_valid = 1'b0;
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end
        s_valid = 1'b1;
        s_data  = px;
        s_sof   = sof;
        k_load  = kld;
        t = 0;
        forever begin
            @(negedge clk);
            if (s_ready === 1'b1) break;
            t++;
            if (t > 500) begin
                n_cmp++;
                n_err++;
                $error("FAIL send_timeout: observed s_ready=%b expected 1 within 500 cycles", s_ready);
                break;
            end
        end
        @(posedge clk); #1;
        s_valid = 1'b0;
        s_sof   = 1'b0;
        k_load  = 1'b0;
    endtask

    task automatic send_frame(input int h, input int kld_idx, input logic [9*KW-1:0] knew);
        for (int r = 0; r < h; r++)
            for (int c = 0; c < W; c++) begin
                if (r*W + c == kld_idx) k_in = knew;
                send(8'(img[r][c]), (r == 0 && c == 0), (r*W + c == kld_idx));
            end
    endtask

    task automatic drain(input string tag);
        int t;
        t = 0;
        while (q.size() != 0 && t < 400) begin @(posedge clk); t++; end
        repeat (6) @(posedge clk);
        #1;
        n_cmp++;
        assert (q.size() == 0)
        else begin
            n_err++;
            $error("FAIL drain_%s: observed %0d outputs missing expected 0", tag, q.size());
        end
    endtask

    task automatic set_ramp(input int h);
        for (int r = 0; r < h; r++)
            for (int c = 0; c < W; c++)
                img[r][c] = r*W + c;
    endtask

    task automatic set_cols(input int c0, input int c1, input int c2, input int c3, input int c4);
        for (int r = 0; r < 3; r++) begin
            img[r][0] = c0; img[r][1] = c1; img[r][2] = c2; img[r][3] = c3; img[r][4] = c4;
        end
    endtask

    task automatic set_kern_all(input int v);
        for (int i = 0; i < 9; i++) kern[i] = v;
    endtask

    initial begin
        int n_before;
        logic [9*KW-1:0] kcenter;
        int h;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        assert (m_valid === 1'b0 && m_data === 8'd0 && m_sof === 1'b0 && m_eol === 1'b0)
        else begin
            n_err++;
            $error("FAIL reset_state: observed v=%b d=%0d sof=%b eol=%b expected 0/0/0/0",
                   m_valid, m_data, m_sof, m_eol);
        end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // Reset mid-stream with an output held in the pipe
        stall_chk = 1'b0;
        rdy_force = 1'b0;
        set_kern_all(1);
        load_kernel();
        mode = 2'd0;
        set_ramp(4);
        for (int i = 0; i < 14; i++)
            send(8'(img[i/W][i%W]), (i == 0), 1'b0);
        @(posedge clk);
        @(posedge clk); #1;
        n_cmp++;
        assert (m_valid === 1'b1)
        else begin
            n_err++;
            $error("FAIL pre_reset_valid: observed %b expected 1", m_valid);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        assert (m_valid === 1'b0 && m_data === 8'd0)
        else begin
            n_err++;
            $error("FAIL async_reset: observed v=%b d=%0d expected v=0 d=0", m_valid, m_data);
        end
        @(negedge clk) rst_n = 1'b1;
        rdy_force = 1'b1;
        q.delete();
        load_kernel();
        repeat (2) @(posedge clk); #1;
        n_before = n_out;
        for (int i = 0; i < 15; i++)
            send(8'(img[i/W][i%W]), 1'b0, 1'b0);
        repeat (8) @(posedge clk); #1;
        n_cmp++;
        assert (n_out == n_before)
        else begin
            n_err++;
            $error("FAIL no_sof_drop: observed %0d outputs expected 0", n_out - n_before);
        end
        stall_chk = 1'b1;

        // Ramp frame, all-ones kernel, ABS
        push_exp(54, 1, 0); push_exp(63, 0, 0); push_exp(72, 0, 1);
        push_exp(99, 0, 0); push_exp(108, 0, 0); push_exp(117, 0, 1);
        send_frame(4, -1, '0);
        drain("ramp");

        // Sobel X edge: ABS clamps, RAW wraps, POS floors
        kern[0] = -1; kern[1] = 0; kern[2] = 1;
        kern[3] = -2; kern[4] = 0; kern[5] = 2;
        kern[6] = -1; kern[7] = 0; kern[8] = 1;
        load_kernel();
        set_cols(0, 0, 255, 0, 0);
        mode = 2'd0;
        push_exp(255, 1, 0); push_exp(0, 0, 0); push_exp(255, 0, 1);
        send_frame(3, -1, '0);
        mode = 2'd3;
        push_exp(8'hFC, 1, 0); push_exp(0, 0, 0); push_exp(8'h04, 0, 1);
        send_frame(3, -1, '0);
        mode = 2'd1;
        push_exp(255, 1, 0); push_exp(0, 0, 0); push_exp(0, 0, 1);
        send_frame(3, -1, '0);
        set_cols(255, 255, 0, 0, 0);
        push_exp(0, 1, 0); push_exp(0, 0, 0); push_exp(0, 0, 1);
        send_frame(3, -1, '0);
        drain("sobel");

        // SHIFT mode on a flat image: 90 >>> 2 = 22
        set_kern_all(1);
        load_kernel();
        set_cols(10, 10, 10, 10, 10);
        mode = 2'd2;
        push_exp(22, 1, 0); push_exp(22, 0, 0); push_exp(22, 0, 1);
        send_frame(3, -1, '0);
        drain("shift");

        // Kernel load mid-frame applies only from the next frame
        mode = 2'd0;
        set_ramp(4);
        kcenter = '0;
        kcenter[4*KW +: KW] = 8'd1;
        push_exp(54, 1, 0); push_exp(63, 0, 0); push_exp(72, 0, 1);
        push_exp(99, 0, 0); push_exp(108, 0, 0); push_exp(117, 0, 1);
        send_frame(4, 8, kcenter);
        push_exp(6, 1, 0); push_exp(7, 0, 0); push_exp(8, 0, 1);
        push_exp(11, 0, 0); push_exp(12, 0, 0); push_exp(13, 0, 1);
        send_frame(4, -1, '0);
        // k_load coincident with s_sof takes effect for that frame
        set_kern_all(1);
        push_exp(54, 1, 0); push_exp(63, 0, 0); push_exp(72, 0, 1);
        push_exp(99, 0, 0); push_exp(108, 0, 0); push_exp(117, 0, 1);
        send_frame(4, 0, pack_kern());
        drain("kswap");

        // Random frames under random backpressure and input gaps
        bp_en  = 1'b1;
        gap_en = 1'b1;
        for (int f = 0; f < 4; f++) begin
            h = $urandom_range(3, 6);
            for (int i = 0; i < 9; i++) kern[i] = $urandom_range(0, 255) - 128;
            for (int r = 0; r < h; r++)
                for (int c = 0; c < W; c++)
                    img[r][c] = $urandom_range(0, 255);
            load_kernel();
            mode = 2'($urandom_range(0, 3));
            model_frame(h, mode);
            send_frame(h, -1, '0);
        end
        drain("random");
        bp_en  = 1'b0;
        gap_en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
